// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch pushes {pc, instr}; decode pops the head.
// The slave modport is the queue's view; the master modport is the fetch/decode side.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
);
    logic                     in_valid;
    logic [XLEN-1:0]          in_pc;
    logic [ILEN-1:0]          in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic [XLEN-1:0]          out_pc;
    logic [ILEN-1:0]          out_instr;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode; a redirect (flush) empties it.
// Outputs come straight from registered storage and occupancy, so in->out latency is one cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign q.in_ready  = (cnt != CW'(DEPTH));
    assign q.out_valid = (cnt != '0);
    assign q.out_pc    = mem[rp].pc;
    assign q.out_instr = mem[rp].instr;
    assign q.count     = cnt;

    // A flush cancels any handshake that happens in the same cycle.
    assign push = q.in_valid  & q.in_ready  & ~flush;
    assign pop  = q.out_valid & q.out_ready & ~flush;

    // NOTE: storage has no reset; cnt gates out_valid, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= '{pc: q.in_pc, instr: q.in_instr};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, latency, fill/drain, streaming wrap, flush and full-with-pop.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;

    logic clk;
    logic reset_n;
    logic flush;
    int   n_checks;
    int   n_fail;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) q ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 1ns after the rising edge so outputs have settled.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        q.in_valid  = 1'b0;
        q.in_pc     = '0;
        q.in_instr  = '0;
        q.out_ready = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic push_entry(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] instr);
        q.in_valid = 1'b1;
        q.in_pc    = pc;
        q.in_instr = instr;
        cycle();
        q.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (q.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", q.out_valid); n_fail++; end
        n_checks++;
        if (q.in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", q.in_ready); n_fail++; end
        n_checks++;
        if (q.count !== 3'd0) begin $display("FAIL reset_count got %0d want 0", q.count); n_fail++; end
    endtask

    task automatic test_single();
        q.out_ready = 1'b1;
        q.in_valid  = 1'b1;
        q.in_pc     = 64'h8000_0000;
        q.in_instr  = 32'h0000_0013;
        #1;
        n_checks++;
        if (q.out_valid !== 1'b0) begin $display("FAIL single_no_bypass got %b want 0", q.out_valid); n_fail++; end
        cycle();
        q.in_valid = 1'b0;
        n_checks++;
        if (q.out_valid !== 1'b1) begin $display("FAIL single_out_valid got %b want 1", q.out_valid); n_fail++; end
        n_checks++;
        if (q.out_pc !== 64'h8000_0000) begin $display("FAIL single_out_pc got %h want 80000000", q.out_pc); n_fail++; end
        n_checks++;
        if (q.out_instr !== 32'h0000_0013) begin $display("FAIL single_out_instr got %h want 00000013", q.out_instr); n_fail++; end
        n_checks++;
        if (q.count !== 3'd1) begin $display("FAIL single_count got %0d want 1", q.count); n_fail++; end
        cycle();
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd0) begin $display("FAIL single_count_after_pop got %0d want 0", q.count); n_fail++; end
        n_checks++;
        if (q.out_valid !== 1'b0) begin $display("FAIL single_out_valid_after_pop got %b want 0", q.out_valid); n_fail++; end
    endtask

    task automatic test_fill_drain();
        logic [XLEN-1:0] exp_pc;
        q.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            q.in_valid = 1'b1;
            q.in_pc    = 64'h8000_0000 + 64'(4 * k);
            q.in_instr = 32'(k);
            #1;
            n_checks++;
            if (q.in_ready !== (k < DEPTH)) begin $display("FAIL fill_in_ready k=%0d got %b want %b", k, q.in_ready, (k < DEPTH)); n_fail++; end
            cycle();
        end
        q.in_valid = 1'b0;
        n_checks++;
        if (q.count !== 3'd4) begin $display("FAIL fill_count got %0d want 4", q.count); n_fail++; end
        q.out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            exp_pc = 64'h8000_0000 + 64'(4 * k);
            n_checks++;
            if (q.out_valid !== 1'b1 || q.out_pc !== exp_pc || q.out_instr !== 32'(k)) begin
                $display("FAIL drain_entry k=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         k, q.out_valid, q.out_pc, q.out_instr, exp_pc, 32'(k));
                n_fail++;
            end
            cycle();
        end
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd0 || q.out_valid !== 1'b0) begin $display("FAIL drain_empty got count=%0d v=%b want 0 0", q.count, q.out_valid); n_fail++; end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] exp_pc;
        base = 64'h8000_0100;
        q.out_ready = 1'b0;
        push_entry(base, 32'h100);
        push_entry(base + 64'd4, 32'h101);
        q.out_ready = 1'b1;
        q.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q.in_pc    = base + 64'(4 * (i + 2));
            q.in_instr = 32'h100 + 32'(i + 2);
            exp_pc     = base + 64'(4 * i);
            #1;
            n_checks++;
            if (q.out_pc !== exp_pc || q.out_instr !== 32'h100 + 32'(i)) begin
                $display("FAIL stream_pc i=%0d got pc=%h instr=%h want pc=%h instr=%h", i, q.out_pc, q.out_instr, exp_pc, 32'h100 + 32'(i));
                n_fail++;
            end
            cycle();
            n_checks++;
            if (q.count !== 3'd2) begin $display("FAIL stream_count i=%0d got %0d want 2", i, q.count); n_fail++; end
        end
        q.in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            exp_pc = base + 64'(4 * i);
            n_checks++;
            if (q.out_valid !== 1'b1 || q.out_pc !== exp_pc) begin
                $display("FAIL stream_tail i=%0d got v=%b pc=%h want v=1 pc=%h", i, q.out_valid, q.out_pc, exp_pc);
                n_fail++;
            end
            cycle();
        end
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd0) begin $display("FAIL stream_final_count got %0d want 0", q.count); n_fail++; end
    endtask

    task automatic test_flush();
        q.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_entry(64'h8000_0200 + 64'(4 * k), 32'h200 + 32'(k));
        n_checks++;
        if (q.count !== 3'd3) begin $display("FAIL flush_pre_count got %0d want 3", q.count); n_fail++; end
        flush       = 1'b1;
        q.in_valid  = 1'b1;
        q.in_pc     = 64'h8000_0F00;
        q.in_instr  = 32'hDEAD_0000;
        q.out_ready = 1'b1;
        #1;
        n_checks++;
        if (q.out_valid !== 1'b1) begin $display("FAIL flush_cycle_out_valid got %b want 1", q.out_valid); n_fail++; end
        cycle();
        flush       = 1'b0;
        q.in_valid  = 1'b0;
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd0 || q.out_valid !== 1'b0 || q.in_ready !== 1'b1) begin
            $display("FAIL flush_after got count=%0d v=%b rdy=%b want 0 0 1", q.count, q.out_valid, q.in_ready);
            n_fail++;
        end
        push_entry(64'h8000_1000, 32'h0000_00AB);
        n_checks++;
        if (q.count !== 3'd1 || q.out_valid !== 1'b1 || q.out_pc !== 64'h8000_1000 || q.out_instr !== 32'h0000_00AB) begin
            $display("FAIL flush_next_push got count=%0d v=%b pc=%h instr=%h want 1 1 80001000 000000ab",
                     q.count, q.out_valid, q.out_pc, q.out_instr);
            n_fail++;
        end
        q.out_ready = 1'b1;
        cycle();
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd0) begin $display("FAIL flush_drain_count got %0d want 0", q.count); n_fail++; end
    endtask

    task automatic test_full_pop();
        logic [XLEN-1:0] exp_pc;
        q.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_entry(64'h8000_0300 + 64'(4 * k), 32'h300 + 32'(k));
        n_checks++;
        if (q.count !== 3'd4) begin $display("FAIL full_count got %0d want 4", q.count); n_fail++; end
        q.in_valid  = 1'b1;
        q.in_pc     = 64'h8000_0310;
        q.in_instr  = 32'h304;
        q.out_ready = 1'b1;
        #1;
        n_checks++;
        if (q.in_ready !== 1'b0 || q.out_pc !== 64'h8000_0300) begin
            $display("FAIL full_pop_pre got rdy=%b pc=%h want 0 80000300", q.in_ready, q.out_pc);
            n_fail++;
        end
        cycle();
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd3 || q.out_pc !== 64'h8000_0304 || q.in_ready !== 1'b1) begin
            $display("FAIL full_pop_post got count=%0d pc=%h rdy=%b want 3 80000304 1", q.count, q.out_pc, q.in_ready);
            n_fail++;
        end
        cycle();
        q.in_valid = 1'b0;
        n_checks++;
        if (q.count !== 3'd4) begin $display("FAIL full_repush_count got %0d want 4", q.count); n_fail++; end
        q.out_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            exp_pc = 64'h8000_0300 + 64'(4 * k);
            n_checks++;
            if (q.out_valid !== 1'b1 || q.out_pc !== exp_pc) begin
                $display("FAIL full_drain k=%0d got v=%b pc=%h want v=1 pc=%h", k, q.out_valid, q.out_pc, exp_pc);
                n_fail++;
            end
            cycle();
        end
        q.out_ready = 1'b0;
        n_checks++;
        if (q.count !== 3'd0) begin $display("FAIL full_final_count got %0d want 0", q.count); n_fail++; end
    endtask

    task automatic test_async_reset();
        q.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_entry(64'h8000_0400 + 64'(4 * k), 32'h400 + 32'(k));
        n_checks++;
        if (q.count !== 3'd3) begin $display("FAIL areset_pre_count got %0d want 3", q.count); n_fail++; end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (q.count !== 3'd0 || q.out_valid !== 1'b0 || q.in_ready !== 1'b1) begin
            $display("FAIL areset_immediate got count=%0d v=%b rdy=%b want 0 0 1", q.count, q.out_valid, q.in_ready);
            n_fail++;
        end
        #2;
        reset_n = 1'b1;
        cycle();
        push_entry(64'h8000_0500, 32'h500);
        n_checks++;
        if (q.count !== 3'd1 || q.out_pc !== 64'h8000_0500) begin
            $display("FAIL areset_after_push got count=%0d pc=%h want 1 80000500", q.count, q.out_pc);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_full_pop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction queue between the fetch stage and decode. Buffers fetched {pc, instr} entries in a small circular FIFO so decode back-pressure and fetch stalls are decoupled. Drops all entries on a pipeline redirect (branch or flushall). Feeds decode with a registered valid/ready interface.

Parameters:
DEPTH, 4, number of entries (power of two, >= 2)
XLEN, 64, PC width in bits
ILEN, 32, instruction width in bits

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  redirect (branch taken or flushall); discards queue contents
in_valid  input  1  fetch presents a valid entry
in_pc  input  XLEN  PC of the incoming entry
in_instr  input  ILEN  instruction word of the incoming entry
in_ready  output  1  queue can accept an entry this cycle
out_valid  output  1  head entry valid for decode
out_pc  output  XLEN  PC of the head entry
out_instr  output  ILEN  instruction of the head entry
out_ready  input  1  decode consumes the head this cycle
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry circular buffer; read pointer rp and write pointer wp, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter cnt.
- Reset (reset_n low, asynchronous): rp=0, wp=0, cnt=0; out_valid=0, in_ready=1, count=0. out_pc/out_instr don't-care while out_valid=0 (bench checks them only when out_valid=1). Reset asserted mid-operation discards all entries immediately.
- in_ready = (cnt != DEPTH), combinational from cnt only (no dependence on out_ready).
- out_valid = (cnt != 0); out_pc/out_instr = entry at rp, read from registered storage.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- push: write {in_pc,in_instr} at wp, wp <= wp+1. pop: rp <= rp+1.
- cnt update: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest; no combinational in->out bypass.
- Full: in_ready=0, in_valid ignored, contents unchanged. Simultaneous pop when full frees a slot only from the next cycle.
- Empty: out_valid=0; out_ready ignored.
- Simultaneous push and pop with 0<cnt<DEPTH: both performed, cnt unchanged, order preserved.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no loss or duplication; FIFO order strictly preserved.
- flush: highest priority; at the next edge rp=wp=0, cnt=0. Any push or pop in the same cycle is cancelled. The flush cycle itself still drives out_valid from the old cnt, but decode ignores it under flush. Entries presented by fetch in the cycle after flush are accepted normally.
- No X propagation: unwritten entries never reach out_* while out_valid=1.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0; pulse reset_n low mid-run with 3 entries -> count=0 asynchronously, before the next edge.
- Push pc=0x80000000/instr=0x00000013 with out_ready=1 -> out_valid=1 exactly 1 cycle later with the same pc/instr; count returns to 0 after the pop.
- out_ready=0, push 5 entries at pc 0x80000000+4k with DEPTH=4 -> in_ready=0 after the 4th, 5th not accepted, count=4; then drain -> pcs 0x80000000..0x8000000C in order.
- Continuous push+pop for 10 cycles with cnt=2 -> count stays 2, pointers wrap, output pc sequence strictly +4 with no gaps or repeats.
- count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the entry presented during flush is dropped; the next push at pc=0x80001000 appears at out_pc.
- Full queue, out_ready=1 and in_valid=1 same cycle -> pop occurs, push rejected (in_ready=0), count=3; push accepted next cycle.
